// File: rtl/bram_req_arb.sv
// ---------------------------------------------------------------------------
// bram_req_arb
//   Two-client (A/B) round-robin arbiter in front of a BRAM window. One
//   client request is granted at a time. It is either rejected locally
//   (address out of window or not word aligned) or forwarded to the write or
//   read controller. Completion is then reported to the granted client as a
//   one-cycle rsp pulse.
//
// Ports
//   clk, arst_n                      clock, async active-low reset
//   {a,b}_req_valid/ready            client request handshake (ready is comb)
//   {a,b}_req_we/addr/wdata          request payload (byte address)
//   {a,b}_rsp_valid/err/rdata        completion pulse, error flag, read data
//   wr_valid/ready, wr_addr/wr_data  write-controller handshake + payload
//   rd_valid/ready, rd_addr/rd_data  read-controller handshake + data
//   busy                             FSM is not idle
// ---------------------------------------------------------------------------
module bram_req_arb #(
   parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        a_req_valid,
   output logic        a_req_ready,
   input  logic        a_req_we,
   input  logic [31:0] a_req_addr,
   input  logic [31:0] a_req_wdata,
   output logic        a_rsp_valid,
   output logic        a_rsp_err,
   output logic [31:0] a_rsp_rdata,
   input  logic        b_req_valid,
   output logic        b_req_ready,
   input  logic        b_req_we,
   input  logic [31:0] b_req_addr,
   input  logic [31:0] b_req_wdata,
   output logic        b_rsp_valid,
   output logic        b_rsp_err,
   output logic [31:0] b_rsp_rdata,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        wr_valid,
   input  logic        wr_ready,
   output logic [31:0] rd_addr,
   input  logic [31:0] rd_data,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RSP} state_e;

   state_e      state_q;
   logic        gnt_q;       // granted client: 0 = A, 1 = B
   logic        last_q;      // last served client: 0 = A, 1 = B
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        wr_valid_q;
   logic        rd_valid_q;
   logic        a_rsp_valid_q;
   logic        b_rsp_valid_q;

   logic        idle;
   logic        gnt_b;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_err;

   assign idle = (state_q == S_IDLE);

   // B wins when it is alone, or on a tie when A was served last.
   assign gnt_b = b_req_valid & (~a_req_valid | ~last_q);

   // Ready is combinational from valid; it is also gated by arst_n so that
   // every output reads 0 while reset is held.
   assign a_req_ready = arst_n & idle & a_req_valid & ~gnt_b;
   assign b_req_ready = arst_n & idle & gnt_b;

   always_comb begin
      req_we    = gnt_b ? b_req_we    : a_req_we;
      req_addr  = gnt_b ? b_req_addr  : a_req_addr;
      req_wdata = gnt_b ? b_req_wdata : a_req_wdata;
      req_err   = (req_addr >= ADDR_LIMIT) || (req_addr[1:0] != 2'b00);
   end

   // NOTE: state is updated with non-blocking assignments only, so every
   // branch below sees the values from the previous cycle regardless of order.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q       <= S_IDLE;
         gnt_q         <= 1'b0;
         last_q        <= 1'b1;   // B counts as served last so A wins the first tie
         addr_q        <= '0;
         wdata_q       <= '0;
         rdata_q       <= '0;
         err_q         <= 1'b0;
         wr_valid_q    <= 1'b0;
         rd_valid_q    <= 1'b0;
         a_rsp_valid_q <= 1'b0;
         b_rsp_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (a_req_valid || b_req_valid) begin
                  gnt_q   <= gnt_b;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  rdata_q <= '0;
                  err_q   <= req_err;
                  if (req_err) begin
                     // Rejected locally: nothing goes downstream.
                     a_rsp_valid_q <= ~gnt_b;
                     b_rsp_valid_q <= gnt_b;
                     state_q       <= S_RSP;
                  end else if (req_we) begin
                     wr_valid_q <= 1'b1;
                     state_q    <= S_WR;
                  end else begin
                     rd_valid_q <= 1'b1;
                     state_q    <= S_RD;
                  end
               end
            end
            S_WR: begin
               if (wr_ready) begin
                  wr_valid_q    <= 1'b0;
                  a_rsp_valid_q <= ~gnt_q;
                  b_rsp_valid_q <= gnt_q;
                  state_q       <= S_RSP;
               end
            end
            S_RD: begin
               if (rd_ready) begin
                  rd_valid_q    <= 1'b0;
                  rdata_q       <= rd_data;
                  a_rsp_valid_q <= ~gnt_q;
                  b_rsp_valid_q <= gnt_q;
                  state_q       <= S_RSP;
               end
            end
            S_RSP: begin
               a_rsp_valid_q <= 1'b0;
               b_rsp_valid_q <= 1'b0;
               err_q         <= 1'b0;
               rdata_q       <= '0;
               last_q        <= gnt_q;
               state_q       <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign wr_valid = wr_valid_q;
   assign rd_valid = rd_valid_q;
   assign wr_addr  = addr_q;
   assign wr_data  = wdata_q;
   assign rd_addr  = addr_q;
   assign busy     = ~idle;

   // Response payload is shared; each client only sees it with its own pulse.
   assign a_rsp_valid = a_rsp_valid_q;
   assign b_rsp_valid = b_rsp_valid_q;
   assign a_rsp_err   = a_rsp_valid_q & err_q;
   assign b_rsp_err   = b_rsp_valid_q & err_q;
   assign a_rsp_rdata = a_rsp_valid_q ? rdata_q : '0;
   assign b_rsp_rdata = b_rsp_valid_q ? rdata_q : '0;

endmodule

// File: tb/tb_bram_req_arb.sv
// ---------------------------------------------------------------------------
// tb_bram_req_arb
//   Directed self-checking bench for bram_req_arb. Inputs change 1 ns after
//   the rising edge; outputs are checked 2 ns after it.
// ---------------------------------------------------------------------------
module tb_bram_req_arb;

   logic        clk;
   logic        arst_n;
   logic        a_req_valid, a_req_ready, a_req_we;
   logic [31:0] a_req_addr, a_req_wdata;
   logic        a_rsp_valid, a_rsp_err;
   logic [31:0] a_rsp_rdata;
   logic        b_req_valid, b_req_ready, b_req_we;
   logic [31:0] b_req_addr, b_req_wdata;
   logic        b_rsp_valid, b_rsp_err;
   logic [31:0] b_rsp_rdata;
   logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
   logic        wr_valid, wr_ready, rd_valid, rd_ready, busy;

   int n_checks = 0;
   int n_fail   = 0;

   bram_req_arb #(.ADDR_LIMIT(32'h0000_1000)) dut (
      .clk(clk), .arst_n(arst_n),
      .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
      .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
      .a_rsp_valid(a_rsp_valid), .a_rsp_err(a_rsp_err), .a_rsp_rdata(a_rsp_rdata),
      .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
      .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
      .b_rsp_valid(b_rsp_valid), .b_rsp_err(b_rsp_err), .b_rsp_rdata(b_rsp_rdata),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      arst_n = 1'b0;
      a_req_valid = 1'b1;
      b_req_valid = 1'b1;
      #1;
      n_checks++;
      if ({a_req_ready, b_req_ready, wr_valid, rd_valid, busy, a_rsp_valid, b_rsp_valid} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 0000000",
                  {a_req_ready, b_req_ready, wr_valid, rd_valid, busy, a_rsp_valid, b_rsp_valid});
      end
      n_checks++;
      if ({wr_addr, wr_data, rd_addr, a_rsp_rdata, b_rsp_rdata} !== 160'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h %h %h want 0", wr_addr, wr_data, rd_addr);
      end
      repeat (3) step();
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      arst_n      = 1'b1;
   endtask

   // Write A, wr_ready three cycles after wr_valid; also the first grant
   // right after reset release.
   task automatic test_write_a();
      a_req_valid = 1'b1; a_req_we = 1'b1;
      a_req_addr = 32'h10; a_req_wdata = 32'hDEADBEEF;
      #1;
      n_checks++;
      if ({a_req_ready, b_req_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL wr_a_grant: got %b want 10", {a_req_ready, b_req_ready});
      end
      step();
      a_req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) wr_ready = 1'b1;
         #1;
         n_checks++;
         if ({wr_valid, rd_valid, busy, wr_addr, wr_data} !== {3'b101, 32'h10, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL wr_a_hold[%0d]: got %b %h %h want 101 00000010 deadbeef",
                     i, {wr_valid, rd_valid, busy}, wr_addr, wr_data);
         end
         step();
      end
      wr_ready = 1'b0;
      #1;
      n_checks++;
      if ({wr_valid, a_rsp_valid, a_rsp_err, b_rsp_valid, a_rsp_rdata} !== {4'b0100, 32'h0}) begin
         n_fail++;
         $display("FAIL wr_a_rsp: got %b %h want 0100 00000000",
                  {wr_valid, a_rsp_valid, a_rsp_err, b_rsp_valid}, a_rsp_rdata);
      end
      step();
      #1;
      n_checks++;
      if ({a_rsp_valid, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL wr_a_done: got %b want 00", {a_rsp_valid, busy});
      end
   endtask

   // Client inputs changing after acceptance must not reach the downstream.
   task automatic test_latch();
      a_req_valid = 1'b1; a_req_we = 1'b1;
      a_req_addr = 32'h20; a_req_wdata = 32'h1234_5678;
      #1;
      n_checks++;
      if (a_req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL latch_grant: got %b want 1", a_req_ready);
      end
      step();
      a_req_valid = 1'b0; a_req_we = 1'b0;
      a_req_addr = 32'h1003; a_req_wdata = 32'h0;
      #1;
      n_checks++;
      if ({wr_valid, wr_addr, wr_data} !== {1'b1, 32'h20, 32'h1234_5678}) begin
         n_fail++;
         $display("FAIL latch_c1: got %b %h %h want 1 00000020 12345678", wr_valid, wr_addr, wr_data);
      end
      step();
      a_req_addr = 32'hFFFF_FFF0; a_req_wdata = 32'hFFFF_FFFF;
      wr_ready = 1'b1;
      #1;
      n_checks++;
      if ({wr_valid, wr_addr, wr_data} !== {1'b1, 32'h20, 32'h1234_5678}) begin
         n_fail++;
         $display("FAIL latch_c2: got %b %h %h want 1 00000020 12345678", wr_valid, wr_addr, wr_data);
      end
      step();
      wr_ready = 1'b0;
      #1;
      n_checks++;
      if ({a_rsp_valid, a_rsp_err, wr_valid} !== 3'b100) begin
         n_fail++;
         $display("FAIL latch_rsp: got %b want 100", {a_rsp_valid, a_rsp_err, wr_valid});
      end
      step();
   endtask

   // Read B of the word written earlier; a stray wr_ready in RD is ignored.
   task automatic test_read_b();
      b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 32'h10; b_req_wdata = 32'h0;
      #1;
      n_checks++;
      if ({a_req_ready, b_req_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL rd_b_grant: got %b want 01", {a_req_ready, b_req_ready});
      end
      step();
      b_req_valid = 1'b0;
      wr_ready = 1'b1;
      rd_data  = 32'h0BAD_0BAD;
      #1;
      n_checks++;
      if ({rd_valid, wr_valid, rd_addr} !== {2'b10, 32'h10}) begin
         n_fail++;
         $display("FAIL rd_b_req: got %b %h want 10 00000010", {rd_valid, wr_valid}, rd_addr);
      end
      step();
      wr_ready = 1'b0;
      rd_ready = 1'b1;
      rd_data  = 32'hDEADBEEF;
      #1;
      n_checks++;
      if ({rd_valid, b_rsp_valid, rd_addr} !== {2'b10, 32'h10}) begin
         n_fail++;
         $display("FAIL rd_b_ignore_wr: got %b %h want 10 00000010", {rd_valid, b_rsp_valid}, rd_addr);
      end
      step();
      rd_ready = 1'b0;
      rd_data  = 32'h0;
      #1;
      n_checks++;
      if ({rd_valid, b_rsp_valid, b_rsp_err, a_rsp_valid, b_rsp_rdata, a_rsp_rdata}
          !== {4'b0100, 32'hDEADBEEF, 32'h0}) begin
         n_fail++;
         $display("FAIL rd_b_rsp: got %b %h %h want 0100 deadbeef 00000000",
                  {rd_valid, b_rsp_valid, b_rsp_err, a_rsp_valid}, b_rsp_rdata, a_rsp_rdata);
      end
      step();
   endtask

   // Both clients valid for six grants; last served is B, so A goes first.
   task automatic test_round_robin();
      int       ng = 0;
      int       na = 0;
      int       nb = 0;
      bit [5:0] order = '0;
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h100;
      b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 32'h200;
      rd_ready = 1'b1; rd_data = 32'h5555_AAAA;
      for (int cyc = 0; cyc < 18; cyc++) begin
         if (ng == 6) begin
            a_req_valid = 1'b0;
            b_req_valid = 1'b0;
         end
         #1;
         if (a_req_ready && ng < 6) begin
            order[ng] = 1'b0; ng++;
         end else if (b_req_ready && ng < 6) begin
            order[ng] = 1'b1; ng++;
         end
         if (a_rsp_valid) na++;
         if (b_rsp_valid) nb++;
         step();
      end
      rd_ready = 1'b0;
      n_checks++;
      if (ng !== 6 || order !== 6'b101010) begin
         n_fail++;
         $display("FAIL rr_order: got %0d grants order %b want 6 grants order 101010", ng, order);
      end
      n_checks++;
      if (na !== 3 || nb !== 3) begin
         n_fail++;
         $display("FAIL rr_rsp_count: got a=%0d b=%0d want a=3 b=3", na, nb);
      end
   endtask

   // Out-of-window and misaligned addresses: error at T+1, nothing downstream.
   task automatic test_error();
      a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h1000; a_req_wdata = 32'h1;
      #1;
      n_checks++;
      if (a_req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL err_lim_grant: got %b want 1", a_req_ready);
      end
      step();
      a_req_valid = 1'b0;
      #1;
      n_checks++;
      if ({a_rsp_valid, a_rsp_err, wr_valid, rd_valid, b_rsp_valid, a_rsp_rdata} !== {5'b11000, 32'h0}) begin
         n_fail++;
         $display("FAIL err_lim_rsp: got %b %h want 11000 00000000",
                  {a_rsp_valid, a_rsp_err, wr_valid, rd_valid, b_rsp_valid}, a_rsp_rdata);
      end
      step();
      #1;
      n_checks++;
      if ({a_rsp_valid, busy, wr_valid, rd_valid} !== 4'b0000) begin
         n_fail++;
         $display("FAIL err_lim_idle: got %b want 0000", {a_rsp_valid, busy, wr_valid, rd_valid});
      end
      // Next request in the very next idle cycle (two-cycle error throughput).
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h2;
      #1;
      n_checks++;
      if (a_req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL err_align_grant: got %b want 1", a_req_ready);
      end
      step();
      a_req_valid = 1'b0;
      #1;
      n_checks++;
      if ({a_rsp_valid, a_rsp_err, wr_valid, rd_valid, b_rsp_valid, a_rsp_rdata} !== {5'b11000, 32'h0}) begin
         n_fail++;
         $display("FAIL err_align_rsp: got %b %h want 11000 00000000",
                  {a_rsp_valid, a_rsp_err, wr_valid, rd_valid, b_rsp_valid}, a_rsp_rdata);
      end
      step();
   endtask

   // Reset in WR aborts with no rsp; afterwards a tie goes to A even though
   // A was served last before the reset.
   task automatic test_reset_abort();
      a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h30; a_req_wdata = 32'hCAFE;
      #1;
      n_checks++;
      if (a_req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_grant: got %b want 1", a_req_ready);
      end
      step();
      a_req_valid = 1'b0;
      step();
      #1;
      n_checks++;
      if ({wr_valid, busy} !== 2'b11) begin
         n_fail++;
         $display("FAIL abort_in_wr: got %b want 11", {wr_valid, busy});
      end
      arst_n = 1'b0;
      #1;
      n_checks++;
      if ({wr_valid, busy, a_rsp_valid, b_rsp_valid, rd_valid} !== 5'b00000) begin
         n_fail++;
         $display("FAIL abort_async: got %b want 00000", {wr_valid, busy, a_rsp_valid, b_rsp_valid, rd_valid});
      end
      step();
      step();
      arst_n = 1'b1;
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h40;
      b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 32'h80;
      #1;
      n_checks++;
      if ({a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid} !== 4'b1000) begin
         n_fail++;
         $display("FAIL abort_tie: got %b want 1000", {a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid});
      end
      step();
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      rd_ready = 1'b1; rd_data = 32'h0000_0040;
      #1;
      n_checks++;
      if ({rd_valid, rd_addr} !== {1'b1, 32'h40}) begin
         n_fail++;
         $display("FAIL abort_rd: got %b %h want 1 00000040", rd_valid, rd_addr);
      end
      step();
      rd_ready = 1'b0;
      #1;
      n_checks++;
      if ({a_rsp_valid, b_rsp_valid, a_rsp_rdata} !== {2'b10, 32'h40}) begin
         n_fail++;
         $display("FAIL abort_after_rsp: got %b %h want 10 00000040", {a_rsp_valid, b_rsp_valid}, a_rsp_rdata);
      end
      step();
   endtask

   initial begin
      arst_n = 1'b0;
      a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0;
      b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
      wr_ready = 1'b0; rd_ready = 1'b0; rd_data = '0;
      step();
      test_reset();
      test_write_a();
      test_latch();
      test_read_b();
      test_round_robin();
      test_error();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
